// File: rtl/clk_div_bank.sv
// ============================================================================
// clk_div_bank : bank of run-time programmable, glitch-free clock dividers.
// Optional macro CLK_DIV_BANK_SYNC_EN adds a 2-flop ch_en synchroniser.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_bank #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] locked
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_STOP  = 2'd2;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] pend;
  logic              cfg_fire;
  logic [DIV_W-1:0]  cfg_eff;

  // A single pending slot is shared by the whole bank.
  assign cfg_ready = ~|pend;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_eff   = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

`ifdef CLK_DIV_BANK_SYNC_EN
  logic [NUM_CH-1:0] en_meta;
  logic [NUM_CH-1:0] en_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta <= '0;
      en_sync <= '0;
    end else begin
      en_meta <= ch_en;
      en_sync <= en_meta;
    end
  end

  assign en = en_sync;
`else
  assign en = ch_en;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] pend_div;
    logic             pend_r;
    logic             wrap;
    logic             sel;
    logic             clk_nxt;
    logic             tick_nxt;
    logic             lock_nxt;
    logic             clk_q;
    logic             tick_q;
    logic             lock_q;

    assign wrap = (cnt == ratio - 1'b1);
    assign sel  = cfg_fire && (cfg_ch == CH_W'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= S_IDLE;
        cnt      <= '0;
        ratio    <= DIV_RST;
        pend_div <= DIV_RST;
        pend_r   <= 1'b0;
      end else begin
        state <= state_nxt;
        if (state == S_IDLE || wrap) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        // Pending ratio lands exactly when the new period starts at cnt=0.
        if (state != S_IDLE && wrap && pend_r) begin
          ratio  <= pend_div;
          pend_r <= 1'b0;
        end
        if (sel) begin
          if (state == S_IDLE) begin
            ratio <= cfg_eff;
          end else begin
            pend_div <= cfg_eff;
            pend_r   <= 1'b1;
          end
        end
      end
    end

    // Stops are deferred to the wrap so the last high phase is never cut.
    always_comb begin
      state_nxt = state;
      case (state)
        S_IDLE:  if (en[i]) state_nxt = S_RUN;
        S_RUN:   if (!en[i]) state_nxt = wrap ? S_IDLE : S_STOP;
        S_STOP: begin
          if (en[i]) begin
            state_nxt = S_RUN;
          end else if (wrap) begin
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    always_comb begin
      clk_nxt  = (state != S_IDLE) && (cnt < (ratio >> 1));
      tick_nxt = (state != S_IDLE) && (cnt == '0);
      lock_nxt = (state == S_RUN) && !pend_r;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        lock_q <= 1'b0;
      end else begin
        clk_q  <= clk_nxt;
        tick_q <= tick_nxt;
        lock_q <= lock_nxt;
      end
    end

    assign pend[i]     = pend_r;
    assign div_clk[i]  = clk_q;
    assign div_tick[i] = tick_q;
    assign locked[i]   = lock_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// tb_clk_div_bank : directed scoreboard bench for clk_div_bank (NUM_CH=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_bank;

  localparam int N     = 3;
  localparam int DIV_W = 8;
  localparam int CH_W  = 2;
  localparam int W     = 3 * N + 1;

  logic             clk;
  logic             rst;
  logic [N-1:0]     ch_en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [N-1:0]     div_clk;
  logic [N-1:0]     div_tick;
  logic [N-1:0]     locked;

  clk_div_bank #(
    .NUM_CH      (N),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (2),
    .CH_W        (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .div_clk   (div_clk),
    .div_tick  (div_tick),
    .locked    (locked)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] mask;
    logic [W-1:0] exp;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  logic [W-1:0] act;
  int           vectors = 0;
  int           miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: output vector is {cfg_ready, locked, div_tick, div_clk}.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {cfg_ready, locked, div_tick, div_clk};
      vectors++;
      if ((act & cur.mask) !== (cur.exp & cur.mask)) begin
        miscompares++;
        $display("FAIL %s: got %b want %b (mask %b)", cur.tag, act, cur.exp, cur.mask);
      end
    end
  end

  // Per-cycle codes for channel ch (clk/tick/locked):
  // 0=000 H=111 h=101 l=001 U=110 u=100; '-'=00x '+'=10x '*'=11x
  // rdy: '1'/'0' checks cfg_ready, anything else or short string skips it.
  // quiet: channels whose clk/tick/locked must stay 0.
  task automatic wave(input string tag, input int ch, input string pat,
                      input string rdy, input logic [N-1:0] quiet);
    for (int i = 0; i < pat.len(); i++) begin
      logic [W-1:0] m;
      logic [W-1:0] e;
      logic         ck;
      logic         tk;
      logic         lk;
      logic         lm;
      byte          c;
      m  = '0;
      e  = '0;
      ck = 1'b0;
      tk = 1'b0;
      lk = 1'b0;
      lm = 1'b1;
      c  = pat[i];
      case (c)
        "H": begin ck = 1'b1; tk = 1'b1; lk = 1'b1; end
        "h": begin ck = 1'b1; lk = 1'b1; end
        "l": lk = 1'b1;
        "U": begin ck = 1'b1; tk = 1'b1; end
        "u": ck = 1'b1;
        "-": lm = 1'b0;
        "+": begin ck = 1'b1; lm = 1'b0; end
        "*": begin ck = 1'b1; tk = 1'b1; lm = 1'b0; end
        default: ;
      endcase
      for (int j = 0; j < N; j++) begin
        if (quiet[j]) begin
          m[j]       = 1'b1;
          m[N + j]   = 1'b1;
          m[2*N + j] = 1'b1;
        end
      end
      m[ch]       = 1'b1;
      e[ch]       = ck;
      m[N + ch]   = 1'b1;
      e[N + ch]   = tk;
      m[2*N + ch] = lm;
      e[2*N + ch] = lk;
      if (i < rdy.len() && (rdy[i] == "1" || rdy[i] == "0")) begin
        m[3*N] = 1'b1;
        e[3*N] = (rdy[i] == "1");
      end
      @(posedge clk);
      sb.push_back('{tag: $sformatf("%s[%0d]", tag, i), mask: m, exp: e});
      #1;
    end
  endtask

  task automatic cfg(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
  endtask

  initial begin
    logic [W-1:0] rexp;
    rst       = 1'b1;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    repeat (2) @(posedge clk);
    #1;
    wave("reset", 0, "0", "1", 3'b111);
    rst = 1'b0;

    // Default ratio 2 on ch0, others silent
    ch_en = 3'b001;
    wave("ch0_div2", 0, "0HlHlHl", "1111111", 3'b110);
    ch_en = 3'b000;
    wave("ch0_stop2", 0, "H-00", "", 3'b110);

    // Ratio 5 loaded while idle
    cfg(1, 5);
    wave("cfg_idle", 1, "0", "1", 3'b101);
    cfg_valid = 1'b0;
    ch_en = 3'b010;
    wave("ch1_div5", 1, "0HhlllHhlllH", "111111111111", 3'b101);
    ch_en = 3'b000;
    wave("ch1_stop", 1, "h---0", "", 3'b101);

    // Ratio 4 -> 6 change requested mid-period
    cfg(0, 4);
    wave("cfg_r4", 0, "0", "1", 3'b110);
    cfg_valid = 1'b0;
    ch_en = 3'b001;
    wave("ch0_div4", 0, "0HhllHhllH", "", 3'b110);
    cfg(0, 6);
    wave("pend_acc", 0, "h", "0", 3'b110);
    cfg_valid = 1'b0;
    wave("pend_apply", 0, "00HhhlllH", "011111111", 3'b110);
    wave("r6", 0, "hhll", "1111", 3'b110);

    // cfg_div=1 accepted on the wrap edge: deferred one full period
    cfg(0, 1);
    wave("cfg_at_wrap", 0, "l", "0", 3'b110);
    cfg_valid = 1'b0;
    wave("wrap_pend", 0, "Uuu000HlH", "000001111", 3'b110);
    ch_en = 3'b000;
    wave("stop_at_wrap", 0, "l0", "", 3'b110);

    // Config and enable on the same edge; stop and restart
    cfg(0, 4);
    ch_en = 3'b001;
    wave("cfg_en", 0, "0", "1", 3'b110);
    cfg_valid = 1'b0;
    wave("ch0_div4b", 0, "HhllHhll", "", 3'b110);
    ch_en = 3'b000;
    wave("stop_full", 0, "H+--00", "", 3'b110);
    ch_en = 3'b001;
    wave("restart", 0, "0HhllH", "", 3'b110);
    ch_en = 3'b000;
    wave("drop", 0, "h", "", 3'b110);
    ch_en = 3'b001;
    wave("reraise", 0, "-lHhllH", "", 3'b110);
    ch_en = 3'b000;
    wave("stop_c", 0, "h--0", "", 3'b110);

    // Out-of-range channel is swallowed
    cfg(3, 7);
    wave("bad_ch", 0, "0", "1", 3'b111);
    cfg_valid = 1'b0;
    wave("bad_ch_after", 0, "0", "1", 3'b111);

    // cfg_div=0 clamps to ratio 2
    cfg(2, 0);
    wave("cfg_div0", 2, "0", "1", 3'b011);
    cfg_valid = 1'b0;
    ch_en = 3'b100;
    wave("ch2_div0", 2, "0HlHl", "11111", 3'b011);
    ch_en = 3'b000;
    wave("ch2_stop", 2, "H-0", "", 3'b011);
    ch_en = 3'b010;
    wave("ch1_kept", 1, "0HhlllH", "", 3'b101);

    // Asynchronous reset mid-period, then defaults
    rexp = '0;
    rexp[W-1] = 1'b1;
    @(posedge clk);
    sb.push_back('{tag: "async_rst", mask: {W{1'b1}}, exp: rexp});
    #1;
    rst   = 1'b1;
    ch_en = 3'b000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wave("post_rst", 0, "0", "1", 3'b111);
    ch_en = 3'b001;
    wave("ch0_default", 0, "0HlHl", "11111", 3'b110);
    ch_en = 3'b000;

    repeat (3) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
